fast_shutter_ctrl: RTL and testbench

Controls a bistable fast optical shutter. Takes an open/close command from a hardware source or a software source. Emits a direction level plus a fixed-width actuation pulse. Uses the two feedback contacts to confirm travel, measure actuation time and flag failures. Sits between the timing/laser-control logic, the register file and the shutter driver pins.

---
 rtl/fast_shutter_ctrl_pkg.sv | 19 +
 rtl/fast_shutter_ctrl_if.sv | 36 +++
 rtl/fast_shutter_fb_filter.sv | 89 ++++++++
 rtl/fast_shutter_ctrl.sv | 152 +++++++++++++++
 tb/tb_fast_shutter_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fast_shutter_ctrl_pkg.sv
// Shared definitions for the fast shutter controller.
//   - FSM state encoding (IDLE / DRIVE / WAIT)
//   - Feedback contact codes {in1, in2}: CLOSED = 2'b10, OPEN = 2'b01
//   - fb_code_for(): feedback code expected once the shutter reaches a target
package fast_shutter_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [1:0] FB_CLOSED = 2'b10;
    localparam logic [1:0] FB_OPEN   = 2'b01;

    // Contact 1 is high when closed, contact 2 is high when open.
    function automatic logic [1:0] fb_code_for(input logic open_target);
        return open_target ? FB_OPEN : FB_CLOSED;
    endfunction

endpackage

// File: rtl/fast_shutter_ctrl_if.sv
// Bundle of command, feedback and driver signals of the fast shutter controller.
//   Commands : fast_shutter_set_i/en_i (hardware), soft_fast_shutter_set_i/en_i (software)
//   Feedback : fast_back_in1_i (closed contact), fast_back_in2_i (open contact)
//   Outputs  : out1 (actuation pulse), out2 (direction), err_act, act_time[31:0], state
// Modports: master = stimulus/register side, slave = controller.
interface fast_shutter_ctrl_if;

    logic        fast_shutter_set_i;
    logic        fast_shutter_en_i;
    logic        soft_fast_shutter_set_i;
    logic        soft_fast_shutter_en_i;
    logic        fast_back_in1_i;
    logic        fast_back_in2_i;
    logic        fast_shutter_out1_o;
    logic        fast_shutter_out2_o;
    logic        fast_shutter_err_act_o;
    logic [31:0] fast_shutter_act_time_o;
    logic        fast_shutter_state_o;

    modport master (
        output fast_shutter_set_i, fast_shutter_en_i,
        output soft_fast_shutter_set_i, soft_fast_shutter_en_i,
        output fast_back_in1_i, fast_back_in2_i,
        input  fast_shutter_out1_o, fast_shutter_out2_o, fast_shutter_err_act_o,
        input  fast_shutter_act_time_o, fast_shutter_state_o
    );

    modport slave (
        input  fast_shutter_set_i, fast_shutter_en_i,
        input  soft_fast_shutter_set_i, soft_fast_shutter_en_i,
        input  fast_back_in1_i, fast_back_in2_i,
        output fast_shutter_out1_o, fast_shutter_out2_o, fast_shutter_err_act_o,
        output fast_shutter_act_time_o, fast_shutter_state_o
    );

endinterface

// File: rtl/fast_shutter_fb_filter.sv
// Feedback conditioning for the two shutter contacts.
//   clk_i, rst_i (async, active-low)
//   back_in1_i, back_in2_i : raw asynchronous contacts
//   code_o  : {in1,in2} pattern accepted after FILTER_CYCLES stable cycles
//   state_o : 1 = open, 0 = closed; holds on invalid codes 00/11
module fast_shutter_fb_filter
    import fast_shutter_ctrl_pkg::*;
#(
    parameter int FILTER_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       back_in1_i,
    input  logic       back_in2_i,
    output logic [1:0] code_o,
    output logic       state_o
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] meta_q;
    logic [1:0] sync_q;

    assign raw = {back_in1_i, back_in2_i};

    // Two-flop synchronizer per contact.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    meta_q[gi] <= 1'b0;
                    sync_q[gi] <= 1'b0;
                end else begin
                    meta_q[gi] <= raw[gi];
                    sync_q[gi] <= meta_q[gi];
                end
            end
        end
    endgenerate

    logic [1:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    filt_q, filt_d;
    logic          state_q, state_d;

    // A new pattern restarts the stability count; once it has been seen
    // FILTER_CYCLES times in a row it becomes the accepted code.
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        if (sync_q != cand_q) begin
            cand_d = sync_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            filt_d = cand_q;
        end

        // Position follows the accepted code in the same cycle it is accepted.
        state_d = state_q;
        if (filt_d == FB_CLOSED) begin
            state_d = 1'b0;
        end else if (filt_d == FB_OPEN) begin
            state_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cand_q  <= '0;
            cnt_q   <= '0;
            filt_q  <= '0;
            state_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            state_q <= state_d;
        end
    end

    assign code_o  = filt_q;
    assign state_o = state_q;

endmodule

// File: rtl/fast_shutter_ctrl.sv
// Bistable fast shutter controller.
//   clk_i : system clock
//   rst_i : asynchronous active-low reset
//   bus   : command inputs, feedback contacts and driver/status outputs
// Selects software-over-hardware command, issues a direction level plus a
// fixed PULSE_CYCLES actuation pulse, times travel until filtered feedback
// confirms, and flags a sticky error after TIMEOUT_CYCLES.
module fast_shutter_ctrl
    import fast_shutter_ctrl_pkg::*;
#(
    parameter int PULSE_CYCLES   = 100000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_CYCLES  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fast_shutter_ctrl_if.slave bus
);

    localparam logic [31:0] PULSE_LIM   = 32'(PULSE_CYCLES);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    logic [1:0] fb_code;
    logic       fb_state;

    fast_shutter_fb_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_fb_filter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .back_in1_i (bus.fast_back_in1_i),
        .back_in2_i (bus.fast_back_in2_i),
        .code_o     (fb_code),
        .state_o    (fb_state)
    );

    logic [1:0]  fsm_q, fsm_d;
    logic        target_q, target_d;
    logic        out1_q, out1_d;
    logic        out2_q, out2_d;
    logic        err_q, err_d;
    logic [31:0] act_time_q, act_time_d;
    logic [31:0] timer_q, timer_d;
    logic        confirmed_q, confirmed_d;   // feedback already confirmed during DRIVE

    logic        cmd_valid;
    logic        cmd;
    logic        request;
    logic        fb_ok;
    logic [31:0] timer_inc;

    always_comb begin
        if (bus.soft_fast_shutter_en_i) begin
            cmd_valid = 1'b1;
            cmd       = bus.soft_fast_shutter_set_i;
        end else if (bus.fast_shutter_en_i) begin
            cmd_valid = 1'b1;
            cmd       = bus.fast_shutter_set_i;
        end else begin
            cmd_valid = 1'b0;
            cmd       = target_q;
        end
        request   = cmd_valid && (cmd != target_q);
        fb_ok     = (fb_code == fb_code_for(target_q));
        timer_inc = (timer_q == '1) ? timer_q : timer_q + 32'd1;
    end

    always_comb begin
        fsm_d       = fsm_q;
        target_d    = target_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        err_d       = err_q;
        act_time_d  = act_time_q;
        timer_d     = timer_q;
        confirmed_d = confirmed_q;

        case (fsm_q)
            ST_IDLE: begin
                if (request) begin
                    target_d    = cmd;
                    out2_d      = cmd;
                    out1_d      = 1'b1;
                    err_d       = 1'b0;
                    timer_d     = 32'd1;   // timer reads 1 in the first DRIVE cycle
                    confirmed_d = 1'b0;
                    fsm_d       = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                timer_d = timer_inc;
                if (fb_ok && !confirmed_q) begin
                    act_time_d  = timer_q;
                    confirmed_d = 1'b1;
                end
                // The pulse always runs its full width, even if travel
                // is already confirmed.
                if (timer_q >= PULSE_LIM) begin
                    out1_d = 1'b0;
                    fsm_d  = (confirmed_q || fb_ok) ? ST_IDLE : ST_WAIT;
                end
            end

            ST_WAIT: begin
                timer_d = timer_inc;
                if (fb_ok) begin
                    act_time_d = timer_q;
                    fsm_d      = ST_IDLE;
                end else if (timer_q >= TIMEOUT_LIM) begin
                    err_d      = 1'b1;
                    act_time_d = TIMEOUT_LIM;
                    fsm_d      = ST_IDLE;
                end
            end

            default: begin
                fsm_d  = ST_IDLE;
                out1_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fsm_q       <= ST_IDLE;
            target_q    <= 1'b0;
            out1_q      <= 1'b0;
            out2_q      <= 1'b0;
            err_q       <= 1'b0;
            act_time_q  <= '0;
            timer_q     <= '0;
            confirmed_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            target_q    <= target_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            err_q       <= err_d;
            act_time_q  <= act_time_d;
            timer_q     <= timer_d;
            confirmed_q <= confirmed_d;
        end
    end

    assign bus.fast_shutter_out1_o     = out1_q;
    assign bus.fast_shutter_out2_o     = out2_q;
    assign bus.fast_shutter_err_act_o  = err_q;
    assign bus.fast_shutter_act_time_o = act_time_q;
    assign bus.fast_shutter_state_o    = fb_state;

endmodule

// File: tb/tb_fast_shutter_ctrl.sv
// Self-checking bench for fast_shutter_ctrl: directed reset / command-flip /
// mid-pulse-reset scenarios plus randomized command transactions checked
// against a transaction-level model of the shutter and its controller.
module tb_fast_shutter_ctrl;

    localparam int P  = 50;
    localparam int TO = 500;
    localparam int F  = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    fast_shutter_ctrl_if bus ();

    fast_shutter_ctrl #(
        .PULSE_CYCLES   (P),
        .TIMEOUT_CYCLES (TO),
        .FILTER_CYCLES  (F)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Model: commanded target, physical shutter position, sticky error and
    // the window the last captured actuation time must fall into.
    bit m_target = 1'b0;
    bit m_pos    = 1'b0;
    bit m_err    = 1'b0;
    int m_act_lo = 0;
    int m_act_hi = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_pos(input bit pos);
        m_pos = pos;
        bus.fast_back_in1_i = ~pos;
        bus.fast_back_in2_i = pos;
    endtask

    task automatic set_cmd(input bit s_en, input bit s_set, input bit h_en, input bit h_set);
        bus.soft_fast_shutter_en_i  = s_en;
        bus.soft_fast_shutter_set_i = s_set;
        bus.fast_shutter_en_i       = h_en;
        bus.fast_shutter_set_i      = h_set;
    endtask

    task automatic check_act_window(input string tag);
        int a;
        a = int'(bus.fast_shutter_act_time_o);
        check_val($sformatf("%s act_time=%0d in [%0d,%0d]", tag, a, m_act_lo, m_act_hi),
                  32'((a >= m_act_lo) && (a <= m_act_hi)), 32'd1);
    endtask

    task automatic check_status(input string tag);
        check_val({tag, " out2"},  32'(bus.fast_shutter_out2_o),    32'(m_target));
        check_val({tag, " err"},   32'(bus.fast_shutter_err_act_o), 32'(m_err));
        check_val({tag, " state"}, 32'(bus.fast_shutter_state_o),   32'(m_pos));
        check_act_window(tag);
    endtask

    // Wait (bounded) for the actuation pulse to appear.
    task automatic wait_pulse(input string tag, output bit seen);
        int n;
        n = 0;
        while (!bus.fast_shutter_out1_o && n < 5) begin
            step();
            n++;
        end
        seen = bus.fast_shutter_out1_o;
        check_val({tag, " pulse_start"}, 32'(seen), 32'd1);
    endtask

    // One command transaction; feedback follows after `delay` cycles of the
    // pulse unless the shutter is stuck.
    task automatic run_txn(input int id, input bit s_en, input bit s_set, input bit h_en,
                           input bit h_set, input int delay, input bit stuck);
        bit v, c, exp_pulse, seen, prev;
        int high, rises, bound;
        v = s_en | h_en;
        c = s_en ? s_set : h_set;
        exp_pulse = v && (c != m_target);
        set_cmd(s_en, s_set, h_en, h_set);
        $display("txn %0d: soft_en=%0d soft_set=%0d hw_en=%0d hw_set=%0d pulse_expected=%0d delay=%0d stuck=%0d",
                 id, s_en, s_set, h_en, h_set, exp_pulse, delay, stuck);
        if (!exp_pulse) begin
            high = 0;
            repeat (10) begin
                step();
                if (bus.fast_shutter_out1_o) high++;
            end
            check_val("no_pulse high_cycles", 32'(high), 32'd0);
            check_status("no_pulse");
            return;
        end
        wait_pulse("txn", seen);
        if (!seen) return;
        m_target = c;
        m_err    = 1'b0;
        if (stuck) bound = TO + 10;
        else bound = (delay + F + 12 > P + 5) ? delay + F + 12 : P + 5;
        high = 0; rises = 0; prev = 1'b0;
        for (int t = 1; t <= bound; t++) begin
            if (bus.fast_shutter_out1_o) high++;
            if (bus.fast_shutter_out1_o && !prev) rises++;
            prev = bus.fast_shutter_out1_o;
            if (t == delay && !stuck) set_pos(c);
            step();
        end
        check_val("txn pulse_width", 32'(high), 32'(P));
        check_val("txn pulse_count", 32'(rises), 32'd1);
        if (stuck) begin
            m_err = 1'b1;
            m_act_lo = TO; m_act_hi = TO;
            check_val("txn err_timeout", 32'(bus.fast_shutter_err_act_o), 32'd1);
            check_val("txn act_timeout", bus.fast_shutter_act_time_o, 32'(TO));
            // Free the shutter by hand so position matches target again.
            set_pos(c);
            repeat (F + 10) step();
        end else begin
            // Contact change -> 2 sync stages + F stable cycles + capture.
            m_act_lo = delay + F + 1;
            m_act_hi = delay + F + 5;
        end
        check_status("txn");
    endtask

    // Command flips during WAIT: no extra pulse while busy; the final
    // level is re-evaluated once back in IDLE.
    task automatic flip_test();
        bit seen, prev;
        int high, rises, ts, n_set;
        // A: open, flip to closed and back to open during WAIT.
        set_cmd(1'b0, 1'b0, 1'b1, 1'b1);
        wait_pulse("flipA", seen);
        if (!seen) return;
        m_target = 1'b1; m_err = 1'b0;
        high = 0; rises = 0; prev = 1'b0;
        for (int t = 1; t <= 340; t++) begin
            if (bus.fast_shutter_out1_o) high++;
            if (bus.fast_shutter_out1_o && !prev) rises++;
            prev = bus.fast_shutter_out1_o;
            if (t == 80)  bus.fast_shutter_set_i = 1'b0;
            if (t == 100) bus.fast_shutter_set_i = 1'b1;
            if (t == 300) set_pos(1'b1);
            step();
        end
        m_act_lo = 300 + F + 1; m_act_hi = 300 + F + 5;
        check_val("flipA pulse_count", 32'(rises), 32'd1);
        check_val("flipA pulse_width", 32'(high), 32'(P));
        check_status("flipA");
        $display("txn flipA: open with closed/open flip in WAIT done");

        // B: close, flip to open during WAIT and leave it -> second pulse.
        set_cmd(1'b0, 1'b0, 1'b1, 1'b0);
        wait_pulse("flipB", seen);
        if (!seen) return;
        high = 0; rises = 0; prev = 1'b0; ts = 0; n_set = 0;
        for (int t = 1; t <= 260; t++) begin
            if (bus.fast_shutter_out1_o) high++;
            if (bus.fast_shutter_out1_o && !prev) begin
                rises++;
                if (rises == 2) ts = t;
            end
            prev = bus.fast_shutter_out1_o;
            if (t == 80)  bus.fast_shutter_set_i = 1'b1;
            if (t == 150) set_pos(1'b0);
            if (t == 170) begin set_pos(1'b1); n_set = t; end
            step();
        end
        m_target = 1'b1; m_err = 1'b0;
        m_act_lo = (n_set - ts + 1) + F + 1;
        m_act_hi = (n_set - ts + 1) + F + 5;
        check_val("flipB pulse_count", 32'(rises), 32'd2);
        check_val("flipB pulse_high_total", 32'(high), 32'(2 * P));
        check_status("flipB");
        $display("txn flipB: close with open flip in WAIT -> re-evaluated pulse");
    endtask

    // Reset asserted 20 cycles into a pulse drops all outputs immediately.
    task automatic reset_mid_pulse();
        bit seen;
        set_cmd(1'b1, ~m_target, 1'b0, 1'b0);
        wait_pulse("rst_mid", seen);
        if (!seen) return;
        repeat (19) step();
        check_val("rst_mid out1_before", 32'(bus.fast_shutter_out1_o), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        check_val("rst_mid out1",     32'(bus.fast_shutter_out1_o),  32'd0);
        check_val("rst_mid out2",     32'(bus.fast_shutter_out2_o),  32'd0);
        check_val("rst_mid err",      32'(bus.fast_shutter_err_act_o), 32'd0);
        check_val("rst_mid act_time", bus.fast_shutter_act_time_o,   32'd0);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0);
        set_pos(1'b0);
        repeat (2) step();
        rst_i = 1'b1;
        m_target = 1'b0; m_err = 1'b0; m_act_lo = 0; m_act_hi = 0;
        repeat (F + 10) step();
        check_status("rst_mid after");
        $display("txn rst_mid: reset asserted 20 cycles into pulse");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s_en, s_set, h_en, h_set, stuck;
        int delay;
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0);
        set_pos(1'b0);
        rst_i = 1'b0;
        repeat (2) step();
        check_val("reset out1",     32'(bus.fast_shutter_out1_o),    32'd0);
        check_val("reset out2",     32'(bus.fast_shutter_out2_o),    32'd0);
        check_val("reset err",      32'(bus.fast_shutter_err_act_o), 32'd0);
        check_val("reset act_time", bus.fast_shutter_act_time_o,     32'd0);
        rst_i = 1'b1;
        repeat (F + 10) step();
        check_status("reset settled");
        $display("txn reset: released with feedback closed");

        // Hardware open, feedback after 120 cycles.
        run_txn(0, 1'b0, 1'b0, 1'b1, 1'b1, 120, 1'b0);
        // Software close overrides hardware open.
        run_txn(1, 1'b1, 1'b0, 1'b1, 1'b1, 90, 1'b0);
        // Software open with feedback stuck -> timeout.
        run_txn(2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        // Next accepted command clears the error.
        run_txn(3, 1'b0, 1'b0, 1'b1, 1'b0, 30, 1'b0);
        // Re-asserting the current target gives no pulse.
        run_txn(4, 1'b1, 1'b0, 1'b0, 1'b1, 30, 1'b0);

        flip_test();

        for (int i = 5; i < 30; i++) begin
            s_en  = ($urandom_range(0, 2) == 0);
            s_set = 1'($urandom_range(0, 1));
            h_en  = ($urandom_range(0, 3) != 0);
            h_set = 1'($urandom_range(0, 1));
            delay = int'($urandom_range(5, 200));
            stuck = ($urandom_range(0, 4) == 0);
            run_txn(i, s_en, s_set, h_en, h_set, delay, stuck);
        end

        reset_mid_pulse();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
